channel_scanner: RTL and testbench

Sequential source for the 3-to-8 decoder. It steps a registered 3-bit channel index through the channels enabled in an 8-bit mask, and holds each channel for a programmable dwell time. Its sel output drives the decoder input directly, and sel_valid gates the decoded one-hot. It supports a one-shot frame mode and a continuous frame mode, and provides start/stop control and frame-status pulses.

---
 rtl/channel_scanner.sv | 155 +++++++++++++++
 tb/tb_channel_scanner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/channel_scanner.sv
// Scans a 3-bit channel index across the channels enabled in en_mask, holding each one for dwell+1 cycles.
// sel drives the 3-to-8 decoder; sel_valid qualifies it. Supports one-shot and continuous frames.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; sel keeps its last value, sel_valid=0
//   SCAN  | stepping through the latched mask; busy=1, sel_valid=1
module channel_scanner #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [7:0]         en_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               frame_wrap
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               frame_wrap_q, frame_wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;
  logic               cont_q, cont_d;

  logic               nxt_found;
  logic [2:0]         nxt_idx;

  function automatic logic [2:0] lowest_en(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Lowest enabled channel strictly above the current one; none found means end of frame.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = sel_q;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) > sel_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    sel_valid_d  = sel_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    frame_wrap_d = 1'b0;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    mask_d       = mask_q;
    cont_d       = cont_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (en_mask != 8'd0) begin
            mask_d      = en_mask;
            dwell_d     = dwell;
            cont_d      = continuous;
            sel_d       = lowest_en(en_mask);
            sel_valid_d = 1'b1;
            busy_d      = 1'b1;
            cnt_d       = '0;
            state_d     = ST_SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else if (nxt_found) begin
          sel_d = nxt_idx;
          cnt_d = '0;
        end else begin
          frame_wrap_d = 1'b1;
          cnt_d        = '0;
          if (cont_q) begin
            sel_d = lowest_en(mask_q);
          end else begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= 3'd0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_wrap_q <= 1'b0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      mask_q       <= 8'd0;
      cont_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_wrap_q <= frame_wrap_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
      cont_q       <= cont_d;
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_wrap = frame_wrap_q;

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner: hand-computed sel/pulse sequences for one-shot,
// continuous, single-channel, stop, and mid-scan reset scenarios.
module tb_channel_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] en_mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       done;
  logic       frame_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  channel_scanner #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .en_mask    (en_mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .done       (done),
    .frame_wrap (frame_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] e_sel, input logic e_v,
                          input logic e_busy, input logic e_done, input logic e_fw);
    chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
    chk({tag, ".sel_valid"}, 32'(sel_valid), 32'(e_v));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".frame_wrap"}, 32'(frame_wrap), 32'(e_fw));
  endtask

  initial begin
    logic [2:0] seq_a [9];
    logic [2:0] e_sel;
    logic       e_fw;

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    en_mask = 8'h00; dwell = 8'd0;
    tick(); tick();
    rst = 1'b0;
    chk_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Empty-mask start: single done pulse, never enters SCAN.
    start = 1'b1; en_mask = 8'h00;
    tick();
    chk_outs("empty_start", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_outs("empty_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // One-shot, mask 0010_0101, dwell 2.
    seq_a = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5};
    start = 1'b1; en_mask = 8'b0010_0101; dwell = 8'd2; continuous = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 0) begin
        start = 1'b0; en_mask = 8'hFF; dwell = 8'd0; continuous = 1'b1;
      end
      chk_outs($sformatf("oneshot[%0d]", k), seq_a[k], 1'b1, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_outs("oneshot_end", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("oneshot_idle", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Continuous, mask 1000_0010, dwell 0: 1,7,1,7 with wrap on each return to 1.
    start = 1'b1; en_mask = 8'b1000_0010; dwell = 8'd0; continuous = 1'b1;
    tick();
    start = 1'b0;
    chk_outs("alt[0]", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_outs("alt[1]", 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_outs("alt[2]", 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); chk_outs("alt[3]", 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_outs("alt[4]", 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    tick();
    chk_outs("alt_stop", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Single channel 3, dwell 3, continuous: wrap every 4 cycles, then stop on the wrap edge.
    start = 1'b1; en_mask = 8'h08; dwell = 8'd3; continuous = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start = 1'b0;
      e_fw = (k > 1) && (((k - 1) % 4) == 0);
      chk_outs($sformatf("single[%0d]", k), 3'd3, 1'b1, 1'b1, 1'b0, e_fw);
    end
    stop = 1'b1;
    tick();
    chk_outs("single_stop_at_wrap", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // All enabled, dwell 1, continuous; mid-scan mask/dwell change and start are ignored.
    start = 1'b1; en_mask = 8'hFF; dwell = 8'd1; continuous = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      start = 1'b0;
      if (k == 3) begin
        en_mask = 8'h01; dwell = 8'd5; continuous = 1'b0; start = 1'b1;
      end
      e_sel = 3'((k - 1) / 2);
      chk_outs($sformatf("all[%0d]", k), e_sel, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    start = 1'b0;
    stop = 1'b1;
    tick();
    chk_outs("all_stop", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    // stop still high together with start in IDLE: start must be ignored.
    start = 1'b1; en_mask = 8'h01;
    tick();
    chk_outs("stop_over_start", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0; stop = 1'b0;

    // Reset mid-scan at sel=6, then a one-shot on channel 6 alone.
    start = 1'b1; en_mask = 8'hFF; dwell = 8'd0; continuous = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      start = 1'b0;
    end
    chk_outs("pre_rst", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_outs("mid_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    start = 1'b1; en_mask = 8'h40; dwell = 8'd0; continuous = 1'b0;
    tick();
    start = 1'b0;
    chk_outs("post_rst_start", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_outs("post_rst_end", 3'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs("post_rst_idle", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
